// File: rtl/blink_seq_if.sv
// Control/status bundle for blink_seq: time-base tick, burst requests and
// the sequenced LED/status outputs.
interface blink_seq_if #(
  parameter int NW = 4
) ();

  logic          tick;
  logic          start;
  logic          stop;
  logic          repeat_en;
  logic [NW-1:0] nblink;
  logic          led;
  logic          busy;
  logic          burst_done;

  modport master (
    output tick,
    output start,
    output stop,
    output repeat_en,
    output nblink,
    input  led,
    input  busy,
    input  burst_done
  );

  modport slave (
    input  tick,
    input  start,
    input  stop,
    input  repeat_en,
    input  nblink,
    output led,
    output busy,
    output burst_done
  );

endinterface

// File: rtl/blink_seq.sv
// Burst LED sequencer: nblink ON/OFF blinks timed in upstream ticks, then a
// gap, optionally repeating. All outputs are registered.
module blink_seq #(
  parameter int ON_TICKS  = 2,
  parameter int OFF_TICKS = 2,
  parameter int GAP_TICKS = 4,
  parameter int NW        = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  blink_seq_if.slave  bus
);

  localparam int MAX_ON_OFF = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int MAX_TICKS  = (MAX_ON_OFF > GAP_TICKS) ? MAX_ON_OFF : GAP_TICKS;
  localparam int CW         = (MAX_TICKS < 2) ? 1 : $clog2(MAX_TICKS + 1);

  localparam logic [CW-1:0] ON_LAST  = CW'(ON_TICKS - 1);
  localparam logic [CW-1:0] OFF_LAST = CW'(OFF_TICKS - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] tick_cnt, tick_cnt_n;
  logic [NW-1:0] blinks_left, blinks_left_n;
  logic [NW-1:0] count_latched, count_latched_n;
  logic          done_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      tick_cnt      <= '0;
      blinks_left   <= '0;
      count_latched <= '0;
      bus.led        <= 1'b0;
      bus.busy       <= 1'b0;
      bus.burst_done <= 1'b0;
    end else begin
      state         <= state_n;
      tick_cnt      <= tick_cnt_n;
      blinks_left   <= blinks_left_n;
      count_latched <= count_latched_n;
      bus.led        <= (state_n == ON);
      bus.busy       <= (state_n != IDLE);
      bus.burst_done <= done_n;
    end
  end

  // A phase ends on the tick that makes the count reach its length; that tick
  // clears the counter, so it never counts toward the phase being entered.
  always_comb begin
    state_n         = state;
    tick_cnt_n      = tick_cnt;
    blinks_left_n   = blinks_left;
    count_latched_n = count_latched;
    done_n          = 1'b0;

    if (bus.stop) begin
      state_n    = IDLE;
      tick_cnt_n = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start && (bus.nblink != '0)) begin
            state_n         = ON;
            blinks_left_n   = bus.nblink;
            count_latched_n = bus.nblink;
            tick_cnt_n      = '0;
          end
        end

        ON: begin
          if (bus.tick) begin
            if (tick_cnt == ON_LAST) begin
              state_n    = OFF;
              tick_cnt_n = '0;
              if (blinks_left != '0) begin
                blinks_left_n = blinks_left - 1'b1;
              end
            end else begin
              tick_cnt_n = tick_cnt + 1'b1;
            end
          end
        end

        OFF: begin
          if (bus.tick) begin
            if (tick_cnt == OFF_LAST) begin
              tick_cnt_n = '0;
              if (blinks_left != '0) begin
                state_n = ON;
              end else begin
                state_n = GAP;
                done_n  = 1'b1;
              end
            end else begin
              tick_cnt_n = tick_cnt + 1'b1;
            end
          end
        end

        GAP: begin
          if (bus.tick) begin
            if (tick_cnt == GAP_LAST) begin
              tick_cnt_n = '0;
              if (bus.repeat_en) begin
                state_n       = ON;
                blinks_left_n = count_latched;
              end else begin
                state_n = IDLE;
              end
            end else begin
              tick_cnt_n = tick_cnt + 1'b1;
            end
          end
        end

        default: begin
          state_n    = IDLE;
          tick_cnt_n = '0;
        end
      endcase
    end
  end

endmodule

// File: doc/blink_seq.md
BLINK_SEQ -- requirements
Module: blink_seq

Interface
REQ-001 Parameter: ON_TICKS, default 2, ticks LED held high per blink (>=1).
REQ-002 Parameter: OFF_TICKS, default 2, ticks LED held low between blinks (>=1).
REQ-003 Parameter: GAP_TICKS, default 4, ticks LED held low after a burst (>=1).
REQ-004 Parameter: NW, default 4, width of the blink-count field.
REQ-005 Port: clk  in  1  single clock, all state updates on posedge.
REQ-006 Port: rst_n  in  1  asynchronous, active-low reset.
REQ-007 Port: tick  in  1  one-cycle time-base pulse from the upstream blink counter's flg output.
REQ-008 Port: start  in  1  level-sampled request to begin bursts.
REQ-009 Port: stop  in  1  abort request.
REQ-010 Port: repeat_en  in  1  1 = restart a burst after each gap, 0 = single burst.
REQ-011 Port: nblink  in  NW  blinks per burst, sampled on accepted start.
REQ-012 Port: led  out  1  sequenced LED drive, registered.
REQ-013 Port: busy  out  1  high in every state except IDLE, registered.
REQ-014 Port: burst_done  out  1  one-cycle pulse at end of each burst, registered.

Function
REQ-015 States SHALL be IDLE, ON, OFF, GAP; led = 1 only in ON.
REQ-016 IDLE: start=1, stop=0, nblink!=0 SHALL latch nblink into blinks_left, clear tick counter, and enter ON next cycle (led high 1 cycle after start).
REQ-017 IDLE: start with nblink=0 SHALL be ignored; block stays IDLE, no burst_done.
REQ-018 Tick counter SHALL advance only on cycles with tick=1; non-tick cycles hold all state.
REQ-019 ON: on the ON_TICKS-th tick SHALL go to OFF, decrement blinks_left, clear tick counter.
REQ-020 OFF: on the OFF_TICKS-th tick, blinks_left!=0 -> ON; blinks_left=0 -> GAP with burst_done=1 for that single transition cycle.
REQ-021 GAP: on the GAP_TICKS-th tick, repeat_en=1 -> ON with blinks_left reloaded from the latched count (not live nblink); repeat_en=0 -> IDLE.
REQ-022 Latched count SHALL be unaffected by nblink changes while busy.
REQ-023 stop=1 in any state SHALL force IDLE, led=0, tick counter cleared on the next edge; stop has priority over start and over tick.
REQ-024 start while busy SHALL be ignored.
REQ-025 Tick counter width SHALL hold max(ON_TICKS, OFF_TICKS, GAP_TICKS); no wrap inside a phase.
REQ-026 blinks_left SHALL never underflow; decrement only from a nonzero value.
REQ-027 tick coincident with a state entry cycle SHALL NOT count toward the new phase.

Reset
REQ-028 rst_n=0 SHALL asynchronously force IDLE, led=0, busy=0, burst_done=0, counters and latched count to 0.
REQ-029 Reset deasserted mid-burst then reasserted SHALL abandon the burst with no burst_done.
REQ-030 First start after reset release SHALL behave as REQ-016.

Verification
REQ-031 Defaults, nblink=3, start pulse, tick every 4 cycles -> led high/low 3 times, each phase 2 ticks, burst_done once at OFF->GAP, then IDLE after 4 gap ticks, busy falls.
REQ-032 nblink=0, start -> busy stays 0, led stays 0 for 100 cycles.
REQ-033 repeat_en=1, nblink=2, change nblink to 5 mid-burst -> every burst has exactly 2 blinks, burst_done each burst.
REQ-034 stop asserted in ON mid-phase coincident with tick -> next cycle led=0, busy=0, no burst_done.
REQ-035 rst_n pulsed low between clock edges during OFF -> led, busy drop immediately without clk edge; restart gives full nblink blinks.
REQ-036 tick held 0 for 50 cycles in ON -> led stays 1, no state change; assertion: burst_done never high on two consecutive cycles.
